// File: rtl/fmap_collector.sv
// fmap_collector: streams H*W elements into a flat frame register for max_pooling_single.
// Define FMAP_COLLECTOR_RELU_EN to zero negative (MSB-set) elements on capture.
module fmap_collector #(
    parameter int DATA_BITS = 32,
    parameter int W         = 46,
    parameter int H         = 46
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_BITS-1:0]         in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [0:H*W*DATA_BITS-1]     frame_data,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic                         frame_err
);
    localparam int FB = H * W * DATA_BITS;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);
    localparam int IW = $clog2(FB);

    typedef enum logic {FILL, FULL} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic                 err_q, err_d;
    logic [0:FB-1]        frame_q, frame_d;
    logic [DATA_BITS-1:0] elem;
    logic [IW-1:0]        base;
    logic                 acc, col_end, last_el;

    always_comb begin
`ifdef FMAP_COLLECTOR_RELU_EN
        elem    = in_data[DATA_BITS-1] ? '0 : in_data;
`else
        elem    = in_data;
`endif
        acc     = in_valid && (state_q == FILL);
        col_end = col_q == CW'(W - 1);
        last_el = col_end && (row_q == RW'(H - 1));
        base    = IW'((int'(row_q) * W + int'(col_q)) * DATA_BITS);
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        err_d   = err_q;
        frame_d = frame_q;
        if (acc) begin
            frame_d[base +: DATA_BITS] = elem;
            // in_last must coincide exactly with the final raster position
            err_d = err_q | (last_el != in_last);
            col_d = col_end ? '0 : col_q + CW'(1);
            row_d = col_end ? (last_el ? '0 : row_q + RW'(1)) : row_q;
            state_d = last_el ? FULL : FILL;
        end
        if (state_q == FULL && frame_ready) begin
            state_d = FILL;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            err_q   <= err_d;
            frame_q <= frame_d;
        end
    end

    assign in_ready    = state_q == FILL;
    assign frame_valid = state_q == FULL;
    assign frame_err   = err_q;
    assign frame_data  = frame_q;
endmodule
